rfphoenix_pma_checker: RTL and testbench

Parametrised, pipelined physical-memory-attribute checker for the rfPhoenix MMU path.
- Holds NREG programmable address regions. Each region has start, end, pmt, cta, at and lock fields.
- Looks up each request address against all regions, then checks the requested access type against the matching region's permissions.
- Sits between address generation and the bus interface. Regions are programmed through a CSR port.

---
 rtl/rfphoenix_pma_checker_if.sv | 35 +++
 rtl/rfphoenix_pma_checker.sv | 140 ++++++++++++++
 tb/tb_rfphoenix_pma_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rfphoenix_pma_checker_if.sv
// rfphoenix_pma_checker_if: CSR, request and response signals of the PMA checker
interface rfphoenix_pma_checker_if #(
   parameter int NREG = 16,
   parameter int AWID = 32
);
   localparam int CW = $clog2(NREG) + 3;
   logic          csr_wr;
   logic          csr_rd;
   logic [CW-1:0] csr_adr;
   logic [31:0]   csr_wdat;
   logic [31:0]   csr_rdat;
   logic          csr_rvalid;
   logic          req_valid;
   logic          req_ready;
   logic [AWID-1:0] req_adr;
   logic [2:0]    req_acc;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [4:0]    rsp_region;
   logic [19:0]   rsp_at;
   logic [31:0]   rsp_pmt;
   logic [31:0]   rsp_cta;
   logic          rsp_miss;
   logic          rsp_perm;
   modport master (
      output csr_wr, csr_rd, csr_adr, csr_wdat, req_valid, req_adr, req_acc, rsp_ready,
      input  csr_rdat, csr_rvalid, req_ready, rsp_valid, rsp_region, rsp_at, rsp_pmt, rsp_cta,
             rsp_miss, rsp_perm
   );
   modport slave (
      input  csr_wr, csr_rd, csr_adr, csr_wdat, req_valid, req_adr, req_acc, rsp_ready,
      output csr_rdat, csr_rvalid, req_ready, rsp_valid, rsp_region, rsp_at, rsp_pmt, rsp_cta,
             rsp_miss, rsp_perm
   );
endinterface

// File: rtl/rfphoenix_pma_checker.sv
// rfphoenix_pma_checker: region table plus two-stage address/permission lookup pipeline
module rfphoenix_pma_checker #(
   parameter int          NREG      = 16,
   parameter int          AWID      = 32,
   parameter int          GRAN      = 4,
   parameter logic [31:0] ROM_START = 32'hFFFD0000,
   parameter logic [31:0] ROM_END   = 32'hFFFFFFFF
) (
   input logic clk,
   input logic rst_n,
   rfphoenix_pma_checker_if.slave bus
);
   localparam int RW = $clog2(NREG);
   logic [31:0]     r_start [NREG];
   logic [31:0]     r_end   [NREG];
   logic [31:0]     r_pmt   [NREG];
   logic [31:0]     r_cta   [NREG];
   logic [19:0]     r_at    [NREG];
   logic [NREG-1:0] r_lock;
   logic [RW-1:0]   widx;
   logic [2:0]      fld;
   logic [31:0]     rd_val;
   logic            stall;
   logic            hit;
   logic [RW-1:0]   hidx;
   logic            s1_v;
   logic            s1_hit;
   logic [RW-1:0]   s1_idx;
   logic [19:0]     s1_at;
   logic [31:0]     s1_pmt;
   logic [31:0]     s1_cta;
   logic [2:0]      s1_acc;
   logic            unused;
   assign widx          = bus.csr_adr[RW+2:3];
   assign fld           = bus.csr_adr[2:0];
   assign stall         = bus.rsp_valid & ~bus.rsp_ready;
   assign bus.req_ready = ~stall;
   assign unused        = ^bus.req_adr[GRAN-1:0];
   // CSR read mux over the addressed region's fields
   always_comb begin
      rd_val = fld == 3'd0 ? r_start[widx] :
               fld == 3'd1 ? r_end[widx] :
               fld == 3'd2 ? r_pmt[widx] :
               fld == 3'd3 ? r_cta[widx] :
               fld == 3'd4 ? {12'd0, r_at[widx]} :
               fld == 3'd5 ? {31'd0, r_lock[widx]} : 32'd0;
   end
   // region table: reset image with boot ROM on the top region, locked regions ignore writes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_start[i] <= '1;
            r_end[i]   <= '0;
            r_pmt[i]   <= '0;
            r_cta[i]   <= '0;
            r_at[i]    <= '0;
         end
         r_lock           <= '0;
         r_start[NREG-1]  <= ROM_START;
         r_end[NREG-1]    <= ROM_END;
         r_at[NREG-1]     <= 20'h0000D;
      end else if (bus.csr_wr && !r_lock[widx]) begin
         case (fld)
            3'd0: r_start[widx] <= bus.csr_wdat;
            3'd1: r_end[widx]   <= bus.csr_wdat;
            3'd2: r_pmt[widx]   <= bus.csr_wdat;
            3'd3: r_cta[widx]   <= bus.csr_wdat;
            3'd4: r_at[widx]    <= bus.csr_wdat[19:0];
            3'd5: r_lock[widx]  <= bus.csr_wdat[0];
            default: ;
         endcase
      end
   end
   // registered CSR read port; data holds between reads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.csr_rvalid <= 1'b0;
         bus.csr_rdat   <= '0;
      end else begin
         bus.csr_rvalid <= bus.csr_rd;
         if (bus.csr_rd) bus.csr_rdat <= rd_val;
      end
   end
   // granule range match, lowest index wins (loop runs downward so the last hit is the lowest)
   always_comb begin
      hit  = 1'b0;
      hidx = '0;
      for (int n = NREG - 1; n >= 0; n--) begin
         if (bus.req_adr[AWID-1:GRAN] >= r_start[n][AWID-1:GRAN] &&
             bus.req_adr[AWID-1:GRAN] <= r_end[n][AWID-1:GRAN]) begin
            hit  = 1'b1;
            hidx = RW'(n);
         end
      end
   end
   // stage 1: capture the match and a snapshot of the winning region's attributes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s1_hit <= 1'b0;
         s1_idx <= '0;
         s1_at  <= '0;
         s1_pmt <= '0;
         s1_cta <= '0;
         s1_acc <= '0;
      end else if (!stall) begin
         s1_v <= bus.req_valid;
         if (bus.req_valid) begin
            s1_hit <= hit;
            s1_idx <= hidx;
            s1_at  <= hit ? r_at[hidx] : '0;
            s1_pmt <= hit ? r_pmt[hidx] : '0;
            s1_cta <= hit ? r_cta[hidx] : '0;
            s1_acc <= bus.req_acc;
         end
      end
   end
   // stage 2: response registers with permission check, frozen while stalled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rsp_valid  <= 1'b0;
         bus.rsp_region <= '0;
         bus.rsp_at     <= '0;
         bus.rsp_pmt    <= '0;
         bus.rsp_cta    <= '0;
         bus.rsp_miss   <= 1'b0;
         bus.rsp_perm   <= 1'b0;
      end else if (!stall) begin
         bus.rsp_valid <= s1_v;
         if (s1_v) begin
            bus.rsp_region <= 5'(s1_idx);
            bus.rsp_at     <= s1_at;
            bus.rsp_pmt    <= s1_pmt;
            bus.rsp_cta    <= s1_cta;
            bus.rsp_miss   <= ~s1_hit;
            bus.rsp_perm   <= s1_hit & |(s1_acc & ~s1_at[2:0]);
         end
      end
   end
endmodule

// File: tb/tb_rfphoenix_pma_checker.sv
// tb_rfphoenix_pma_checker: directed checks of CSR access, lookup, locking, stalls and reset
module tb_rfphoenix_pma_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   rfphoenix_pma_checker_if #(.NREG(16), .AWID(32)) b ();
   rfphoenix_pma_checker dut (.clk(clk), .rst_n(rst_n), .bus(b));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic csr_write(input int idx, input int f, input logic [31:0] d);
      b.csr_wr   = 1'b1;
      b.csr_adr  = {4'(idx), 3'(f)};
      b.csr_wdat = d;
      tick();
      b.csr_wr   = 1'b0;
   endtask

   task automatic csr_read(input string tag, input int idx, input int f, input logic [31:0] exp);
      b.csr_rd  = 1'b1;
      b.csr_adr = {4'(idx), 3'(f)};
      tick();
      b.csr_rd  = 1'b0;
      chk({tag, "_rv"}, 32'(b.csr_rvalid), 32'd1);
      chk(tag, b.csr_rdat, exp);
      tick();
      chk({tag, "_rv0"}, 32'(b.csr_rvalid), 32'd0);
   endtask

   task automatic look(input string tag, input logic [31:0] adr, input logic [2:0] acc,
                       input int rg, input bit miss, input bit perm, input logic [19:0] at);
      b.req_valid = 1'b1;
      b.req_adr   = adr;
      b.req_acc   = acc;
      tick();
      b.req_valid = 1'b0;
      chk({tag, "_early"}, 32'(b.rsp_valid), 32'd0);
      tick();
      chk({tag, "_v"}, 32'(b.rsp_valid), 32'd1);
      chk({tag, "_rg"}, 32'(b.rsp_region), 32'(rg));
      chk({tag, "_miss"}, 32'(b.rsp_miss), 32'(miss));
      chk({tag, "_perm"}, 32'(b.rsp_perm), 32'(perm));
      chk({tag, "_at"}, 32'(b.rsp_at), 32'(at));
      tick();
      chk({tag, "_bub"}, 32'(b.rsp_valid), 32'd0);
   endtask

   logic [31:0] s_adr [4] = '{32'hFFFE0000, 32'h20000000, 32'hFFFFFFF0, 32'hFFFD0000};
   logic [2:0]  s_acc [4] = '{3'b100, 3'b100, 3'b010, 3'b001};
   logic [6:0]  s_exp [4] = '{{2'b00, 5'd15}, {2'b10, 5'd0}, {2'b01, 5'd15}, {2'b00, 5'd15}};

   initial begin
      int sent, got, stalls;
      bit stalled_prev;
      logic [6:0] snap;
      b.csr_wr = 0; b.csr_rd = 0; b.csr_adr = '0; b.csr_wdat = '0;
      b.req_valid = 0; b.req_adr = '0; b.req_acc = '0; b.rsp_ready = 1'b1;
      do_reset();
      chk("rst_rvalid", 32'(b.csr_rvalid), 0);
      chk("rst_rspv", 32'(b.rsp_valid), 0);
      csr_read("boot_start", 15, 0, 32'hFFFD0000);
      csr_read("boot_end", 15, 1, 32'hFFFFFFFF);
      csr_read("boot_at", 15, 4, 32'h0000000D);
      csr_read("r0_start", 0, 0, 32'hFFFFFFFF);
      look("boot_rd", 32'hFFFE0000, 3'b100, 15, 0, 0, 20'hD);
      csr_write(1, 0, 32'h00000000);
      csr_write(1, 1, 32'h1FFFFFFF);
      csr_write(1, 4, 32'hFFF0010F);
      csr_write(1, 2, 32'h12345678);
      csr_write(3, 0, 32'h10000000);
      csr_write(3, 1, 32'h1FFFFFFF);
      csr_write(3, 4, 32'h00000004);
      csr_read("r1_at", 1, 4, 32'h0000010F);
      csr_read("fld6", 1, 6, 32'h0);
      look("prio", 32'h10000000, 3'b010, 1, 0, 0, 20'h10F);
      chk("prio_pmt", b.rsp_pmt, 32'h12345678);
      look("r1_top", 32'h1FFFFFF0, 3'b111, 1, 0, 0, 20'h10F);
      look("miss", 32'h20000000, 3'b100, 0, 1, 0, 20'h0);
      look("below_rom", 32'hFFFCFFF0, 3'b100, 0, 1, 0, 20'h0);
      look("boot_wr", 32'hFFFFFFF0, 3'b010, 15, 0, 1, 20'hD);
      look("boot_none", 32'hFFFFFFF0, 3'b000, 15, 0, 0, 20'hD);
      look("boot_x", 32'hFFFD0000, 3'b001, 15, 0, 0, 20'hD);
      csr_write(2, 2, 32'h0000AAAA);
      b.csr_rd = 1'b1; b.csr_wr = 1'b1; b.csr_adr = {4'd2, 3'd2}; b.csr_wdat = 32'h00005555;
      tick();
      b.csr_rd = 1'b0; b.csr_wr = 1'b0;
      chk("rdwr_old", b.csr_rdat, 32'h0000AAAA);
      tick();
      chk("rdat_hold", b.csr_rdat, 32'h0000AAAA);
      csr_read("rdwr_new", 2, 2, 32'h00005555);
      csr_write(1, 5, 32'h1);
      csr_write(1, 0, 32'h40000000);
      csr_write(1, 5, 32'h0);
      csr_read("lock_start", 1, 0, 32'h0);
      csr_read("lock_bit", 1, 5, 32'h1);
      do_reset();
      chk("rst2_rdat", b.csr_rdat, 32'h0);
      chk("rst2_rspat", 32'(b.rsp_at), 32'h0);
      chk("rst2_rdy", 32'(b.req_ready), 32'h1);
      csr_read("unlock", 1, 5, 32'h0);
      csr_read("r1_rst", 1, 0, 32'hFFFFFFFF);
      sent = 0; got = 0; stalls = 0; stalled_prev = 0; snap = '0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         b.rsp_ready = !(cyc >= 2 && cyc <= 4);
         b.req_valid = sent < 4;
         b.req_adr   = s_adr[sent < 4 ? sent : 0];
         b.req_acc   = s_acc[sent < 4 ? sent : 0];
         #1;
         if (stalled_prev) chk("stall_hold", 32'({b.rsp_miss, b.rsp_perm, b.rsp_region}), 32'(snap));
         stalled_prev = b.rsp_valid && !b.rsp_ready;
         if (stalled_prev) begin
            stalls++;
            chk("stall_rdy", 32'(b.req_ready), 32'h0);
            snap = {b.rsp_miss, b.rsp_perm, b.rsp_region};
         end
         if (b.rsp_valid && b.rsp_ready) begin
            chk($sformatf("strm%0d", got), 32'({b.rsp_miss, b.rsp_perm, b.rsp_region}),
                32'(s_exp[got < 4 ? got : 0]));
            got++;
         end
         if (b.req_valid && b.req_ready) sent++;
         @(posedge clk);
         #0;
      end
      b.req_valid = 1'b0;
      b.rsp_ready = 1'b1;
      #1;
      chk("strm_cnt", 32'(got), 32'd4);
      chk("strm_stalls", 32'(stalls), 32'd3);
      tick();
      chk("strm_nodup", 32'(b.rsp_valid), 32'd0);
      b.req_valid = 1'b1; b.req_adr = 32'hFFFE0000; b.req_acc = 3'b100;
      tick();
      rst_n = 1'b0;
      tick();
      b.req_valid = 1'b0;
      rst_n = 1'b1;
      got = 0;
      for (int i = 0; i < 5; i++) begin
         if (b.rsp_valid) got++;
         tick();
      end
      chk("rst_flight", 32'(got), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
